// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB stage: FSM state encoding, the hard-wired
// zero register index and the word-alignment mask.
package mips_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam int         REG_ZERO        = 0;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage feeding the register-file write port.
// Optional build macro ALIGN_CHECK_EN turns on word-alignment faulting of loads/stores.
//
//   state     | meaning
//   ST_IDLE   | accepting EX results; ALU ops retire next cycle
//   ST_ACCESS | data-memory request outstanding; upstream stalled
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_alu_result,
  input  logic [DW-1:0]   in_store_data,
  input  logic [RW-1:0]   in_dest,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_write,
  output logic [RW-1:0]   wb_reg,
  output logic [DW-1:0]   wb_data,
  output logic [CNTW-1:0] stall_cnt,
  output logic            misalign
);

  state_t        state;
  logic [RW-1:0] dest_q;
  logic          mem_op;

  assign mem_op = in_mem_read || in_mem_write;
  assign stall  = (state == ST_ACCESS);

`ifdef ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (in_alu_result[1:0] & WORD_ALIGN_MASK) != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dest_q     <= '0;
      wb_write   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
`ifdef ALIGN_CHECK_EN
      misalign   <= 1'b0;
`endif
    end else begin
      // Pulsed outputs default low; each retirement raises them for one cycle.
      wb_write <= 1'b0;
`ifdef ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!mem_op) begin
              wb_write <= in_reg_write && (in_dest != RW'(REG_ZERO));
              wb_reg   <= in_dest;
              wb_data  <= in_alu_result;
            end
`ifdef ALIGN_CHECK_EN
            else if (misaligned) begin
              misalign <= 1'b1;
            end
`endif
            else begin
              state      <= ST_ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= in_mem_write;
              dmem_addr  <= AW'(in_alu_result);
              dmem_wdata <= in_store_data;
              dest_q     <= in_dest;
            end
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              wb_write <= (dest_q != RW'(REG_ZERO));
              wb_reg   <= dest_q;
              wb_data  <= dmem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level reference model.
module tb_mem_wb_stage;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_store_data = '0;
  logic [4:0]  in_dest = '0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [15:0] stall_cnt;
  logic        misalign;
  logic        sc_en = 1'b0;
  logic [2:0]  sc_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_dest(in_dest), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_write(wb_write), .wb_reg(wb_reg),
    .wb_data(wb_data), .stall_cnt(stall_cnt), .misalign(misalign)
  );

  sat_counter #(.W(3)) u_sat3 (.clk(clk), .rst_n(rst_n), .en(sc_en), .cnt(sc_cnt));

  // Reference model: one outstanding access record plus the expected output events.
  typedef struct packed {
    logic        busy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  dest;
  } acc_t;

  acc_t        acc;
  logic        e_wb;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic [15:0] e_cnt;
  logic        e_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      e_wb   <= 1'b0;
      e_reg  <= '0;
      e_data <= '0;
      e_cnt  <= '0;
      e_mis  <= 1'b0;
    end else begin
      e_wb  <= 1'b0;
      e_mis <= 1'b0;
      if (acc.busy) begin
        if (e_cnt != 16'hFFFF) e_cnt <= e_cnt + 16'd1;
        if (dmem_ack) begin
          acc.busy <= 1'b0;
          if (!acc.we && acc.dest != 5'd0) begin
            e_wb   <= 1'b1;
            e_reg  <= acc.dest;
            e_data <= dmem_rdata;
          end
        end
      end else if (in_valid) begin
        if (!in_mem_read && !in_mem_write) begin
          if (in_reg_write && in_dest != 5'd0) begin
            e_wb   <= 1'b1;
            e_reg  <= in_dest;
            e_data <= in_alu_result;
          end
        end else if (ALIGN && in_alu_result[1:0] != 2'b00) begin
          e_mis <= 1'b1;
        end else begin
          acc <= '{busy: 1'b1, we: in_mem_write, addr: in_alu_result,
                   wdata: in_store_data, dest: in_dest};
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_stall", 32'(stall), 32'(acc.busy));
        chk("m_req", 32'(dmem_req), 32'(acc.busy));
        if (acc.busy) begin
          chk("m_we", 32'(dmem_we), 32'(acc.we));
          chk("m_addr", dmem_addr, acc.addr);
          chk("m_wdata", dmem_wdata, acc.wdata);
        end
        chk("m_wb_write", 32'(wb_write), 32'(e_wb));
        if (e_wb) begin
          chk("m_wb_reg", 32'(wb_reg), 32'(e_reg));
          chk("m_wb_data", wb_data, e_data);
        end
        chk("m_stall_cnt", 32'(stall_cnt), 32'(e_cnt));
        chk("m_misalign", 32'(misalign), 32'(e_mis));
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] sd);
    in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_reg_write = rw;
    in_dest = dest; in_alu_result = alu; in_store_data = sd;
  endtask

  int ack_wait;

  initial begin
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_write", 32'(wb_write), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;

    // ALU chain: three back-to-back retirements, no stall
    @(negedge clk); drive(0, 0, 1, 5'd4, 32'd6, 32'd0);
    @(negedge clk); drive(0, 0, 1, 5'd5, 32'd3, 32'd0);
    chk("alu0_wb", 32'(wb_write), 32'd1); chk("alu0_reg", 32'(wb_reg), 32'd4);
    chk("alu0_data", wb_data, 32'd6); chk("alu0_stall", 32'(stall), 32'd0);
    @(negedge clk); drive(0, 0, 1, 5'd8, 32'd8, 32'd0);
    chk("alu1_wb", 32'(wb_write), 32'd1); chk("alu1_reg", 32'(wb_reg), 32'd5);
    chk("alu1_data", wb_data, 32'd3); chk("alu1_stall", 32'(stall), 32'd0);
    @(negedge clk); idle();
    chk("alu2_wb", 32'(wb_write), 32'd1); chk("alu2_reg", 32'(wb_reg), 32'd8);
    chk("alu2_data", wb_data, 32'd8);
    @(negedge clk);
    chk("alu_done_wb", 32'(wb_write), 32'd0);

    // Load at 0x10, ack in the third request cycle
    drive(1, 0, 1, 5'd9, 32'h10, 32'd0);
    @(negedge clk); idle();
    chk("ld_req1", 32'(dmem_req), 32'd1); chk("ld_stall1", 32'(stall), 32'd1);
    chk("ld_addr", dmem_addr, 32'h10); chk("ld_we", 32'(dmem_we), 32'd0);
    @(negedge clk); chk("ld_req2", 32'(dmem_req), 32'd1);
    @(negedge clk); chk("ld_req3", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(negedge clk); dmem_ack = 1'b0;
    chk("ld_req_off", 32'(dmem_req), 32'd0); chk("ld_stall_off", 32'(stall), 32'd0);
    chk("ld_wb", 32'(wb_write), 32'd1); chk("ld_reg", 32'(wb_reg), 32'd9);
    chk("ld_data", wb_data, 32'hDEADBEEF); chk("ld_stall_cnt", 32'(stall_cnt), 32'd3);

    // Store at 0x20, same-cycle ack
    drive(0, 1, 0, 5'd2, 32'h20, 32'h55);
    @(negedge clk); idle();
    chk("st_req", 32'(dmem_req), 32'd1); chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_addr", dmem_addr, 32'h20); chk("st_wdata", dmem_wdata, 32'h55);
    chk("st_stall", 32'(stall), 32'd1);
    dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    chk("st_wb", 32'(wb_write), 32'd0); chk("st_stall_off", 32'(stall), 32'd0);
    chk("st_stall_cnt", 32'(stall_cnt), 32'd4);

    // Destination register 0 never written
    drive(0, 0, 1, 5'd0, 32'h99, 32'd0);
    @(negedge clk); idle();
    chk("r0_alu_wb", 32'(wb_write), 32'd0);
    drive(1, 0, 1, 5'd0, 32'h8, 32'd0);
    @(negedge clk); idle(); dmem_ack = 1'b1; dmem_rdata = 32'hAA;
    @(negedge clk); dmem_ack = 1'b0;
    chk("r0_ld_wb", 32'(wb_write), 32'd0);
    chk("r0_stall_cnt", 32'(stall_cnt), 32'd5);

    // Ack while idle is ignored
    dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    chk("idle_ack_wb", 32'(wb_write), 32'd0); chk("idle_ack_stall", 32'(stall), 32'd0);

    // Misaligned load at 0x13
    drive(1, 0, 1, 5'd3, 32'h13, 32'd0);
    @(negedge clk); idle();
`ifdef ALIGN_CHECK_EN
    chk("mis_pulse", 32'(misalign), 32'd1); chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_wb", 32'(wb_write), 32'd0);
    drive(0, 0, 1, 5'd6, 32'h77, 32'd0);
    @(negedge clk); idle();
    chk("mis_clear", 32'(misalign), 32'd0);
    chk("mis_alu_wb", 32'(wb_write), 32'd1); chk("mis_alu_reg", 32'(wb_reg), 32'd6);
    chk("mis_alu_data", wb_data, 32'h77);
`else
    chk("unal_req", 32'(dmem_req), 32'd1); chk("unal_addr", dmem_addr, 32'h13);
    chk("unal_mis", 32'(misalign), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234;
    @(negedge clk); dmem_ack = 1'b0;
    chk("unal_wb", 32'(wb_write), 32'd1); chk("unal_reg", 32'(wb_reg), 32'd3);
`endif

    // Reset while a load is outstanding
    @(negedge clk); drive(1, 0, 1, 5'd7, 32'h40, 32'd0);
    @(negedge clk); idle();
    chk("rstacc_req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc_req", 32'(dmem_req), 32'd0); chk("rstacc_stall", 32'(stall), 32'd0);
    chk("rstacc_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h123;
    @(negedge clk); dmem_ack = 1'b0;
    chk("rstacc_wb", 32'(wb_write), 32'd0); chk("rstacc_stall2", 32'(stall), 32'd0);

    // Randomized traffic with a random-latency memory responder
    ack_wait = int'($urandom_range(0, 3));
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (acc.busy) begin
        if (ack_wait == 0) begin
          dmem_ack = 1'b1; dmem_rdata = $urandom;
          ack_wait = int'($urandom_range(0, 3));
        end else begin
          ack_wait--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        dmem_ack = 1'b1; dmem_rdata = $urandom;
      end
      in_valid      = ($urandom_range(0, 3) != 0);
      in_mem_read   = 1'b0;
      in_mem_write  = 1'b0;
      case ($urandom_range(0, 3))
        1: in_mem_read = 1'b1;
        2: in_mem_write = 1'b1;
        default: ;
      endcase
      in_reg_write  = ($urandom_range(0, 4) != 0);
      in_dest       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      in_alu_result = $urandom;
      if ($urandom_range(0, 3) != 0) in_alu_result[1:0] = 2'b00;
      in_store_data = $urandom;
    end
    @(negedge clk); idle(); dmem_ack = 1'b0;

    // Saturating counter boundary on a narrow instance
    sc_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("sat3_mid", 32'(sc_cnt), 32'd5);
    repeat (5) @(negedge clk);
    chk("sat3_sat", 32'(sc_cnt), 32'd7);
    sc_en = 1'b0;
    @(negedge clk);
    chk("sat3_hold", 32'(sc_cnt), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
